// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, indexes the async IMEM and fills the IF/ID register.
// Optional macro FETCH_ADDR_CHECK_EN adds alignment/range checking with a sticky fetch_fault.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter int unsigned IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid,
  output logic [31:0] fetch_count
`ifdef FETCH_ADDR_CHECK_EN
  ,
  output logic        fetch_fault
`endif
);

  localparam int unsigned PC_W = 32;

  // The IMEM index is only 8 bits wide, so larger memories cannot be addressed.
  if (IMEM_WORDS > 256) begin : g_size_check
    $error("instr_fetch: IMEM_WORDS larger than the 8-bit index can reach");
  end

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_id_instr;
  logic [PC_W-1:0] r_id_pc;
  logic [PC_W-1:0] r_id_pc_plus4;
  logic            r_id_valid;
  logic [PC_W-1:0] r_fetch_count;
  logic [PC_W-1:0] w_pc_plus4;
  logic            w_fault;

  assign w_pc_plus4 = r_pc + PC_W'(4);
  assign imem_addr  = 8'((r_pc - RESET_PC) >> 2);

`ifdef FETCH_ADDR_CHECK_EN
  localparam logic [PC_W-1:0] WORDS_LIMIT = PC_W'(IMEM_WORDS);
  logic r_fetch_fault;

  // Misaligned or beyond-the-image PC; a PC below RESET_PC wraps high and is caught too.
  assign w_fault     = (r_pc[1:0] != 2'b00) || (((r_pc - RESET_PC) >> 2) >= WORDS_LIMIT);
  assign fetch_fault = r_fetch_fault;
`else
  assign w_fault = 1'b0;
`endif

  // Priority: reset > redirect > stall > advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_id_instr    <= '0;
      r_id_pc       <= '0;
      r_id_pc_plus4 <= '0;
      r_id_valid    <= 1'b0;
      r_fetch_count <= '0;
`ifdef FETCH_ADDR_CHECK_EN
      r_fetch_fault <= 1'b0;
`endif
    end else if (redirect) begin
      // Squash the wrong-path instruction; payload fields keep their old values.
      r_pc       <= redirect_pc;
      r_id_valid <= 1'b0;
    end else if (!stall) begin
      if (w_fault) begin
`ifdef FETCH_ADDR_CHECK_EN
        r_fetch_fault <= 1'b1;
`endif
        r_id_valid <= 1'b0;
      end else begin
        r_id_instr    <= imem_instr;
        r_id_pc       <= r_pc;
        r_id_pc_plus4 <= w_pc_plus4;
        r_id_valid    <= 1'b1;
        r_pc          <= w_pc_plus4;
        r_fetch_count <= r_fetch_count + PC_W'(1);
      end
    end
  end

  assign pc          = r_pc;
  assign id_instr    = r_id_instr;
  assign id_pc       = r_id_pc;
  assign id_pc_plus4 = r_id_pc_plus4;
  assign id_valid    = r_id_valid;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed test-plan steps followed by random
// stall/redirect/reset traffic checked against a behavioural fetch model.
module tb_instr_fetch;

  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam int unsigned WORDS = 64;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [7:0]  imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic [31:0] fetch_count;
`ifdef FETCH_ADDR_CHECK_EN
  logic        fetch_fault;
`endif

  logic [31:0] mem [256];
  assign imem_instr = mem[imem_addr];

  instr_fetch #(.RESET_PC(BASE), .IMEM_WORDS(WORDS)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .pc(pc), .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
    .id_valid(id_valid), .fetch_count(fetch_count)
`ifdef FETCH_ADDR_CHECK_EN
    , .fetch_fault(fetch_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state of the fetch stage as described by the rules.
  logic [31:0] m_pc, m_instr, m_idpc, m_idp4, m_cnt;
  logic        m_valid, m_fault;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
`ifdef FETCH_ADDR_CHECK_EN
    return (a % 4 != 0) || (((a - BASE) / 4) >= WORDS);
`else
    return 1'b0;
`endif
  endfunction

  // Apply inputs for one edge, advance the model, then compare every output after the edge.
  task automatic step(input bit rst, input bit stl, input bit rdr, input logic [31:0] rpc);
    logic [31:0] word;
    reset = rst; stall = stl; redirect = rdr; redirect_pc = rpc;
    if (rst) begin
      m_pc = BASE; m_instr = 0; m_idpc = 0; m_idp4 = 0; m_valid = 0; m_cnt = 0; m_fault = 0;
    end else if (rdr) begin
      m_pc = rpc; m_valid = 0;
    end else if (!stl) begin
      if (addr_bad(m_pc)) begin
        m_fault = 1; m_valid = 0;
      end else begin
        word    = (m_pc - BASE) / 4;
        m_instr = mem[word % 256];
        m_idpc  = m_pc;
        m_idp4  = m_pc + 4;
        m_valid = 1;
        m_pc    = m_pc + 4;
        m_cnt   = m_cnt + 1;
      end
    end
    @(posedge clk);
    #1;
    chk("pc", pc, m_pc);
    chk("imem_addr", 32'(imem_addr), ((m_pc - BASE) / 4) % 256);
    chk("id_valid", 32'(id_valid), 32'(m_valid));
    chk("fetch_count", fetch_count, m_cnt);
    if (m_valid) begin
      chk("id_instr", id_instr, m_instr);
      chk("id_pc", id_pc, m_idpc);
      chk("id_pc_plus4", id_pc_plus4, m_idp4);
    end
`ifdef FETCH_ADDR_CHECK_EN
    chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
`endif
  endtask

  initial begin
    logic [31:0] tgt;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_0003;
    mem[2] = 32'h0109_5020;
    mem[8] = 32'h0000_0000;
    reset = 1; stall = 0; redirect = 0; redirect_pc = 0;

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_pc", pc, BASE);
    chk("rst_valid", 32'(id_valid), 0);
    chk("rst_count", fetch_count, 0);

    // Three free-running fetches.
    step(0, 0, 0, 0);
    chk("f0_instr", id_instr, 32'h2008_0005);
    chk("f0_pc", id_pc, 32'h0040_0000);
    step(0, 0, 0, 0);
    chk("f1_instr", id_instr, 32'h2009_0003);
    step(0, 0, 0, 0);
    chk("f2_instr", id_instr, 32'h0109_5020);
    chk("f2_pc", id_pc, 32'h0040_0008);
    chk("f2_addr", 32'(imem_addr), 3);
    chk("f2_count", fetch_count, 3);

    // Two-cycle stall freezes everything, then resumes without loss or duplication.
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("stall_pc", pc, 32'h0040_000C);
    chk("stall_instr", id_instr, 32'h0109_5020);
    chk("stall_count", fetch_count, 3);
    step(0, 0, 0, 0);
    chk("resume_pc", id_pc, 32'h0040_000C);
    chk("resume_count", fetch_count, 4);

    // Redirect: one bubble, then the target fetch (a nop word is still a valid fetch).
    step(0, 0, 1, 32'h0040_0020);
    chk("rdr_valid", 32'(id_valid), 0);
    chk("rdr_pc", pc, 32'h0040_0020);
    chk("rdr_addr", 32'(imem_addr), 8);
    step(0, 0, 0, 0);
    chk("tgt_pc", id_pc, 32'h0040_0020);
    chk("tgt_valid", 32'(id_valid), 1);
    chk("tgt_instr", id_instr, 32'h0000_0000);

    // Redirect beats stall.
    step(0, 1, 1, 32'h0040_0040);
    chk("rdrstall_pc", pc, 32'h0040_0040);
    chk("rdrstall_valid", 32'(id_valid), 0);
    step(0, 0, 0, 0);

    // Reset beats a pending redirect.
    step(1, 0, 1, 32'h0040_0080);
    chk("rstrdr_pc", pc, BASE);
    chk("rstrdr_count", fetch_count, 0);
    step(0, 0, 0, 0);

`ifdef FETCH_ADDR_CHECK_EN
    // Misaligned target faults stickily; a good redirect resumes fetching.
    step(0, 0, 1, 32'h0040_0102);
    step(0, 0, 0, 0);
    chk("flt_fault", 32'(fetch_fault), 1);
    chk("flt_valid", 32'(id_valid), 0);
    chk("flt_pc", pc, 32'h0040_0102);
    step(0, 0, 1, 32'h0040_0000);
    step(0, 0, 0, 0);
    chk("flt_resume_valid", 32'(id_valid), 1);
    chk("flt_sticky", 32'(fetch_fault), 1);
    step(1, 0, 0, 0);
`else
    // PC arithmetic wraps at the top of the address space.
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    chk("wrap_pc", pc, 32'h0000_0000);
    chk("wrap_p4", id_pc_plus4, 32'h0000_0000);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 10)
        tgt = BASE + 4 * $urandom_range(0, WORDS - 1);
      else
        tgt = BASE + $urandom_range(0, 1023);
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 12, tgt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
